abro_pattern_sequencer: RTL and testbench

//   Programmable stimulus sequencer for one abro_state_machine instance.

---
 rtl/abro_pattern_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_abro_pattern_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/abro_pattern_sequencer.sv
// rtl/abro_pattern_sequencer.sv - plays a stored {A,B} step table into one ABRO FSM and counts O responses; ABRO_SEQ_CHECK_EN adds expected-response checking
module abro_pattern_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [6:0]       wr_data,
    input  logic [AW:0]      len,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             A,
    output logic             B,
    input  logic             O,
    input  logic [3:0]       state,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] err_count
);

    // Table entry holds {A,B} and, when checking is built in, {O_exp, state_exp}.
`ifdef ABRO_SEQ_CHECK_EN
    localparam int TW = 7;
`else
    localparam int TW = 2;
`endif
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [TW-1:0]    table_q [DEPTH];
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      n_q, n_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             done_q, done_d;
    logic             sample_q, sample_d;
    logic [CNT_W-1:0] o_cnt_q, o_cnt_d;
    logic [AW:0]      n_start;
    logic [AW-1:0]    idx_inc;
    logic             last_step;
    logic             accept;

`ifdef ABRO_SEQ_CHECK_EN
    // exp_q travels with the driven step; exp_prev_q lines up with its sampled response.
    logic [4:0]       exp_q, exp_d, exp_prev_q;
    logic [CNT_W-1:0] err_q, err_d;
    logic             mismatch;
`else
    logic             unused_inputs;
    assign unused_inputs = ^{state, wr_data[4:0]};
`endif

    // Pattern table: written only while idle, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en && (fsm_q == S_IDLE)) begin
            table_q[wr_addr] <= wr_data[6 -: TW];
        end
    end

    // Next-state, step drive and response counting.
    always_comb begin
        fsm_d     = fsm_q;
        idx_d     = idx_q;
        n_d       = n_q;
        a_d       = 1'b0;
        b_d       = 1'b0;
        done_d    = 1'b0;
        o_cnt_d   = o_cnt_q;
        sample_d  = (fsm_q == S_RUN) && !abort;
        n_start   = (len > DEPTH_N) ? DEPTH_N : len;
        idx_inc   = idx_q + 1'b1;
        last_step = ({1'b0, idx_q} == (n_q - 1'b1));
        accept    = (fsm_q == S_IDLE) && start && !abort;
`ifdef ABRO_SEQ_CHECK_EN
        exp_d     = '0;
        err_d     = err_q;
        mismatch  = (O != exp_prev_q[4]) || (state != exp_prev_q[3:0]);
`endif

        // Abort freezes the counts at whatever they reached.
        if (sample_q && !abort) begin
            if (O && (o_cnt_q != '1)) begin
                o_cnt_d = o_cnt_q + 1'b1;
            end
`ifdef ABRO_SEQ_CHECK_EN
            if (mismatch && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
`endif
        end

        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    n_d     = n_start;
                    idx_d   = '0;
                    o_cnt_d = '0;
`ifdef ABRO_SEQ_CHECK_EN
                    err_d   = '0;
`endif
                    if (n_start != '0) begin
                        fsm_d = S_RUN;
                        a_d   = table_q[0][TW-1];
                        b_d   = table_q[0][TW-2];
`ifdef ABRO_SEQ_CHECK_EN
                        exp_d = table_q[0][4:0];
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    fsm_d = S_IDLE;
                end else if (last_step) begin
                    fsm_d = S_DRAIN;
                end else begin
                    idx_d = idx_inc;
                    a_d   = table_q[idx_inc][TW-1];
                    b_d   = table_q[idx_inc][TW-2];
`ifdef ABRO_SEQ_CHECK_EN
                    exp_d = table_q[idx_inc][4:0];
`endif
                end
            end
            S_DRAIN: begin
                fsm_d  = S_IDLE;
                done_d = !abort;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q      <= S_IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            done_q     <= 1'b0;
            sample_q   <= 1'b0;
            o_cnt_q    <= '0;
`ifdef ABRO_SEQ_CHECK_EN
            exp_q      <= '0;
            exp_prev_q <= '0;
            err_q      <= '0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            a_q        <= a_d;
            b_q        <= b_d;
            done_q     <= done_d;
            sample_q   <= sample_d;
            o_cnt_q    <= o_cnt_d;
`ifdef ABRO_SEQ_CHECK_EN
            exp_q      <= exp_d;
            exp_prev_q <= exp_q;
            err_q      <= err_d;
`endif
        end
    end

    assign busy    = (fsm_q != S_IDLE);
    assign done    = done_q;
    assign A       = a_q;
    assign B       = b_q;
    assign o_count = o_cnt_q;
`ifdef ABRO_SEQ_CHECK_EN
    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_abro_pattern_sequencer.sv
// tb/tb_abro_pattern_sequencer.sv - scoreboard bench for abro_pattern_sequencer with a stand-in ABRO FSM
`timescale 1ns/1ps
module tb_abro_pattern_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [6:0]       wr_data = '0;
    logic [AW:0]      len = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, A, B, O;
    logic [3:0]       state;
    logic [CNT_W-1:0] o_count, err_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [6:0] shadow [DEPTH];

    typedef struct { int cyc; int ab; int busy; } pin_t;
    typedef struct { int cyc; int ocnt; int ecnt; } done_t;
    pin_t  pin_q[$];
    done_t done_q[$];

    abro_pattern_sequencer #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .abort(abort), .busy(busy), .done(done), .A(A), .B(B),
        .O(O), .state(state), .o_count(o_count), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ABRO FSM: 0 IDLE, 1 A seen, 2 B seen, 3 O; {A,B}=00 returns to IDLE.
    function automatic logic [1:0] abro_next(input logic [1:0] st, input logic a, input logic b);
        if (!a && !b) return 2'd0;
        if (st == 2'd3) return 2'd3;
        if (!a && b) return 2'd2;
        if (a && !b && st == 2'd1) return 2'd3;
        return 2'd1;
    endfunction

    logic [1:0] dev_st;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) dev_st <= 2'd0;
        else          dev_st <= abro_next(dev_st, A, B);
    end
    assign O     = (dev_st == 2'd3);
    assign state = 4'b0001 << dev_st;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_pin(input int c, input int ab, input int bz);
        pin_t p;
        p.cyc = c; p.ab = ab; p.busy = bz;
        pin_q.push_back(p);
    endtask

    task automatic push_done(input int c, input int oc, input int ec);
        done_t d;
        d.cyc = c; d.ocnt = oc; d.ecnt = ec;
        done_q.push_back(d);
    endtask

    // Reference: replay the first n table steps through the stand-in FSM and tally.
    task automatic model_run(input int n, output int ocnt, output int ecnt);
        logic [1:0] st;
        logic [4:0] resp;
        st = 2'd0; ocnt = 0; ecnt = 0;
        for (int k = 0; k < n; k++) begin
            st = abro_next(st, shadow[k][6], shadow[k][5]);
            if (st == 2'd3) ocnt++;
            resp = {st == 2'd3, 4'b0001 << st};
            if (resp != shadow[k][4:0]) ecnt++;
        end
        if (ocnt > 255) ocnt = 255;
        if (ecnt > 255) ecnt = 255;
`ifndef ABRO_SEQ_CHECK_EN
        ecnt = 0;
`endif
    endtask

    // Monitor: compares pins on stamped cycles and every done pulse.
    always @(negedge clk) begin
        pin_t  p;
        done_t d;
        if (reset_n) begin
            if (pin_q.size() > 0 && pin_q[0].cyc == cyc) begin
                p = pin_q.pop_front();
                check("ab_pins", int'({A, B}), p.ab);
                check("busy", int'(busy), p.busy);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("o_count", int'(o_count), d.ocnt);
                    check("err_count", int'(err_count), d.ecnt);
                end
            end else if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
                d = done_q.pop_front();
                check("missing_done", 0, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input logic [6:0] data);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
        shadow[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_run(input int l);
        int n, c, oc, ec;
        n = (l > DEPTH) ? DEPTH : l;
        c = cyc;
        len = (AW+1)'(l);
        start = 1'b1;
        if (n == 0) begin
            push_pin(c + 1, 0, 0);
            push_done(c + 1, 0, 0);
        end else begin
            model_run(n, oc, ec);
            for (int k = 0; k < n; k++) push_pin(c + 1 + k, int'(shadow[k][6:5]), 1);
            push_pin(c + n + 1, 0, 1);
            push_pin(c + n + 2, 0, 0);
            push_done(c + n + 2, oc, ec);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drained();
        int guard;
        guard = 0;
        while ((pin_q.size() > 0 || done_q.size() > 0) && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            check("drain_timeout", 1, 0);
            pin_q.delete();
            done_q.delete();
        end
        tick();
    endtask

    logic [6:0] spec_vec [DEPTH];

    initial begin
        int c, nw;
        spec_vec[0] = 7'b00_0_0001; spec_vec[1] = 7'b10_0_0010;
        spec_vec[2] = 7'b01_0_0100; spec_vec[3] = 7'b11_0_0010;
        spec_vec[4] = 7'b10_1_1000; spec_vec[5] = 7'b11_1_1000;
        spec_vec[6] = 7'b11_1_1000; spec_vec[7] = 7'b00_0_0001;
        for (int k = 0; k < DEPTH; k++) shadow[k] = '0;

        // Reset values
        tick(); tick();
        check("rst_A", int'(A), 0);
        check("rst_B", int'(B), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_o_count", int'(o_count), 0);
        check("rst_err_count", int'(err_count), 0);
        reset_n = 1'b1;
        tick();

        // Reference pattern, then with step 4 expectation corrupted
        for (int k = 0; k < DEPTH; k++) write_entry(k, spec_vec[k]);
        start_run(8); wait_drained();
        write_entry(4, 7'b10_0_1000);
        start_run(8); wait_drained();
        write_entry(4, spec_vec[4]);

        // Zero-length run and clamped over-length run
        start_run(0); wait_drained();
        start_run(15); wait_drained();

        // Abort three cycles after start
        c = cyc; len = 8; start = 1'b1;
        for (int k = 0; k < 3; k++) push_pin(c + 1 + k, int'(shadow[k][6:5]), 1);
        push_pin(c + 4, 0, 0);
        push_pin(c + 5, 0, 0);
        tick(); start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_drained();

        // start and abort together while idle
        c = cyc; len = 8; start = 1'b1; abort = 1'b1;
        push_pin(c + 1, 0, 0);
        push_pin(c + 2, 0, 0);
        tick(); start = 1'b0; abort = 1'b0;
        wait_drained();

        // Writes and start while running are ignored; rerun proves the table is intact
        start_run(8);
        tick(); tick();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 7'd0; start = 1'b1; len = 2;
        tick();
        wr_en = 1'b0; start = 1'b0;
        wait_drained();
        start_run(8); wait_drained();

        // Reset mid-run
        start_run(8);
        tick();
        #1 reset_n = 1'b0;
        #1;
        check("midrst_A", int'(A), 0);
        check("midrst_B", int'(B), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_o_count", int'(o_count), 0);
        check("midrst_err_count", int'(err_count), 0);
        pin_q.delete();
        done_q.delete();
        for (int k = 0; k < DEPTH; k++) shadow[k] = '0;
        tick();
        reset_n = 1'b1;
        tick();
        start_run(8); wait_drained();

        // Randomized table contents and lengths
        for (int it = 0; it < 30; it++) begin
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) write_entry($urandom_range(0, DEPTH - 1), 7'($urandom));
            start_run($urandom_range(0, 15));
            wait_drained();
        end

        check("queues_empty", pin_q.size() + done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
